// File: rtl/mul_log2e_arb.sv
// mul_log2e_arb: round-robin arbiter sharing one fixed-latency mul_log2e pipeline
// among NUM_REQ requesters, with in-order tagged responses and a drain handshake. rev 1.0
`default_nettype none

module mul_log2e_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int PIPE_LAT   = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   input  logic [NUM_REQ-1:0]              rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_data,
   output logic [DATA_WIDTH-1:0]           pipe_op,
   output logic                            pipe_vld_in,
   output logic                            pipe_en,
   input  logic [DATA_WIDTH-1:0]           pipe_result,
   input  logic                            pipe_vld_out,
   input  logic                            drain_req,
   output logic                            drained,
   output logic                            busy,
   output logic [$clog2(PIPE_LAT+1)-1:0]   inflight
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(PIPE_LAT+1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    lg;
   logic [IDX_W-1:0]    gnt;
   logic                gnt_vld;
   logic                issue;
   logic                stall;
   logic                rsp_fire;
   logic [CNT_W-1:0]    inflight_nxt;
   logic [IDX_W-1:0]    tag_idx [PIPE_LAT];
   logic [PIPE_LAT-1:0] tag_vld;
   logic [IDX_W-1:0]    tail_idx;
   logic                tail_vld;

   assign tail_idx = tag_idx[PIPE_LAT-1];
   assign tail_vld = tag_vld[PIPE_LAT-1];

   // Response side: the tail tag tells which requester owns the result.
   always_comb begin
      stall     = pipe_vld_out & ~rsp_ready[tail_idx];
      pipe_en   = ~rst_n | ~stall;
      rsp_valid = '0;
      if (rst_n && pipe_vld_out && tail_vld)
         rsp_valid[tail_idx] = 1'b1;
      rsp_fire  = |(rsp_valid & rsp_ready);
      rsp_data  = pipe_result;
   end

   // Round-robin search starting just after the last issued index.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] jj;
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = int'(lg) + k;
         if (j >= NUM_REQ)
            j = j - NUM_REQ;
         jj = IDX_W'(j);
         if (!gnt_vld && req_valid[jj]) begin
            gnt_vld = 1'b1;
            gnt     = jj;
         end
      end
   end

   always_comb begin
      issue       = rst_n & (state == ST_RUN) & pipe_en & gnt_vld;
      req_ready   = '0;
      pipe_vld_in = issue;
      pipe_op     = '0;
      if (issue) begin
         req_ready[gnt] = 1'b1;
         pipe_op        = req_data[gnt*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      inflight_nxt = inflight;
      if (issue && !rsp_fire)
         inflight_nxt = inflight + CNT_W'(1);
      else if (!issue && rsp_fire && inflight != '0)
         inflight_nxt = inflight - CNT_W'(1);
   end

   // DRAIN exits on the post-handshake count so drained rises the cycle after the last response.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:     if (drain_req)            state_nxt = ST_DRAIN;
         ST_DRAIN:   if (inflight_nxt == '0)   state_nxt = ST_DRAINED;
         ST_DRAINED: if (!drain_req)           state_nxt = ST_RUN;
         default:                              state_nxt = ST_RUN;
      endcase
   end

   assign drained = (state == ST_DRAINED);
   assign busy    = (inflight != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         lg       <= IDX_W'(NUM_REQ-1);
         inflight <= '0;
         tag_vld  <= '0;
         for (int k = 0; k < PIPE_LAT; k++)
            tag_idx[k] <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (issue)
            lg <= gnt;
         if (pipe_en) begin
            tag_vld[0] <= issue;
            tag_idx[0] <= gnt;
            for (int k = 1; k < PIPE_LAT; k++) begin
               tag_vld[k] <= tag_vld[k-1];
               tag_idx[k] <= tag_idx[k-1];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mul_log2e_arb.sv
// tb_mul_log2e_arb: scoreboard bench for mul_log2e_arb with a 3-stage pipeline model.
`default_nettype none

module tb_mul_log2e_arb;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int PL = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic [DW-1:0]   pipe_op;
   logic            pipe_vld_in;
   logic            pipe_en;
   logic [DW-1:0]   pipe_result;
   logic            pipe_vld_out;
   logic            drain_req;
   logic            drained;
   logic            busy;
   logic [1:0]      inflight;

   always #5 clk = ~clk;

   mul_log2e_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .pipe_op(pipe_op), .pipe_vld_in(pipe_vld_in), .pipe_en(pipe_en),
      .pipe_result(pipe_result), .pipe_vld_out(pipe_vld_out),
      .drain_req(drain_req), .drained(drained), .busy(busy), .inflight(inflight)
   );

   function automatic logic [DW-1:0] model_f(input logic [DW-1:0] x);
      return {x[DW-2:0], x[DW-1]} ^ 32'h5A5A_5A5A;
   endfunction

   // Pipeline model: fixed latency PL, advances only when enabled, shares rst_n.
   logic [DW-1:0] pd [PL];
   logic [PL-1:0] pv;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         for (int k = 0; k < PL; k++) pd[k] <= '0;
      end else if (pipe_en) begin
         pv[0] <= pipe_vld_in;
         pd[0] <= model_f(pipe_op);
         for (int k = 1; k < PL; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
         end
      end
   end
   assign pipe_result  = pd[PL-1];
   assign pipe_vld_out = pv[PL-1];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } exp_t;
   exp_t q[$];
   int   lg_m;

   // Scoreboard monitor: grants, pushes expected responses on issue, pops on handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         lg_m = NR-1;
      end else begin
         int g;
         check("inflight", 32'(inflight), q.size());
         check("busy", 32'(busy), 32'(q.size() != 0));
         if (rsp_valid != '0) begin
            if (q.size() == 0)
               check("rsp_orphan", 32'(rsp_valid), 0);
            else begin
               check("rsp_valid", 32'(rsp_valid), 1 << q[0].idx);
               check("rsp_data", rsp_data, q[0].data);
               if (|(rsp_valid & rsp_ready))
                  void'(q.pop_front());
            end
         end
         g = -1;
         for (int k = 1; k <= NR; k++) begin
            int j;
            j = (lg_m + k) % NR;
            if (g < 0 && req_valid[j]) g = j;
         end
         if (req_ready != '0) begin
            check("grant", 32'(req_ready), (g < 0) ? 0 : (1 << g));
            check("pipe_vld_in", 32'(pipe_vld_in), 1);
         end
         if (|(req_valid & req_ready) && g >= 0) begin
            check("pipe_op", pipe_op, req_data[g*DW +: DW]);
            q.push_back('{idx: g, data: model_f(req_data[g*DW +: DW])});
            lg_m = g;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, "_pipe_vld_in"}, 32'(pipe_vld_in), 0);
      check({tag, "_pipe_op"}, pipe_op, 0);
      check({tag, "_drained"}, 32'(drained), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_pipe_en"}, 32'(pipe_en), 1);
      check({tag, "_inflight"}, 32'(inflight), 0);
   endtask

   initial begin
      int ord [5] = '{0, 1, 2, 3, 0};
      logic [DW-1:0] d1;

      rst_n     = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      drain_req = 1'b0;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
      #3;
      chk_reset_outputs("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = '0;
      idle(2);

      // Single op from requester 0
      for (int c = 0; c <= 4; c++) begin
         step();
         if (c == 0) begin
            req_valid = 4'b0001;
            req_data[0 +: DW] = 32'h3F80_0000;
         end
         if (c == 1) req_valid = '0;
         smp();
         if (c == 0) begin
            check("t1_req_ready", 32'(req_ready), 32'h1);
            check("t1_pipe_vld_in", 32'(pipe_vld_in), 1);
            check("t1_pipe_op", pipe_op, 32'h3F80_0000);
         end
         if (c >= 1 && c <= 3) check("t1_inflight", 32'(inflight), 1);
         if (c == 3) begin
            check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
            check("t1_rsp_data", rsp_data, model_f(32'h3F80_0000));
         end
         if (c == 4) check("t1_inflight_done", 32'(inflight), 0);
      end

      // All four requesters after a fresh reset
      step();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h4000_0000 + 32'(i * 17);
      for (int c = 0; c <= 7; c++) begin
         step();
         if (c == 0) req_valid = 4'b1111;
         if (c == 5) req_valid = '0;
         smp();
         if (c < 5) check("t2_grant", 32'(req_ready), 1 << ord[c]);
         if (c >= 3) check("t2_rsp", 32'(rsp_valid), 1 << ord[c-3]);
      end
      idle(3);

      // Stall with requester 1 at the output
      d1 = 32'hC0DE_0001;
      req_data[1*DW +: DW] = d1;
      for (int c = 0; c <= 8; c++) begin
         step();
         if (c == 0) begin req_valid = 4'b0010; rsp_ready = 4'b1101; end
         if (c == 1) req_valid = '0;
         if (c == 3) req_valid = 4'b1000;
         if (c == 7) rsp_ready = 4'b1111;
         if (c == 8) req_valid = '0;
         smp();
         if (c == 1 || c == 2) check("t3_bubble_en", 32'(pipe_en), 1);
         if (c >= 3 && c <= 6) begin
            check("t3_stall_en", 32'(pipe_en), 0);
            check("t3_stall_ready", 32'(req_ready), 0);
            check("t3_stall_rsp", 32'(rsp_valid), 32'h2);
            check("t3_stall_data", rsp_data, model_f(d1));
         end
         if (c == 7) begin
            check("t3_resume_en", 32'(pipe_en), 1);
            check("t3_resume_ready", 32'(req_ready), 32'h8);
         end
      end
      idle(6);

      // Drain with three ops in flight
      for (int c = 0; c <= 10; c++) begin
         step();
         if (c == 0) req_valid = 4'b1111;
         if (c == 2) drain_req = 1'b1;
         if (c == 8) drain_req = 1'b0;
         if (c == 10) req_valid = '0;
         smp();
         if (c <= 2) check("t4_grant", 32'(req_ready), 1 << c);
         if (c >= 3 && c <= 8) check("t4_no_ready", 32'(req_ready), 0);
         if (c == 3) check("t4_inflight3", 32'(inflight), 3);
         if (c >= 3 && c <= 5) check("t4_not_drained", 32'(drained), 0);
         if (c >= 6 && c <= 8) check("t4_drained", 32'(drained), 1);
         if (c == 6) check("t4_idle_busy", 32'(busy), 0);
         if (c == 9) begin
            check("t4_run_drained", 32'(drained), 0);
            check("t4_run_grant", 32'(req_ready), 32'h8);
         end
      end
      idle(6);

      // Reset asserted with two ops in flight
      for (int c = 0; c <= 1; c++) begin
         step();
         if (c == 0) req_valid = 4'b0011;
         smp();
      end
      step();
      check("t5_inflight2", 32'(inflight), 2);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t5");
      idle(2);
      rst_n     = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 6; c++) begin
         smp();
         check("t5_no_stale", 32'(rsp_valid), 0);
         step();
      end

      idle(4);
      check("sb_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mul_log2e_arb.md
MUL_LOG2E_ARB -- requirements
Module: mul_log2e_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 4: requester count, range 2..8.
REQ-003 SHALL have parameter PIPE_LAT, default 3: fixed latency of the shared mul_log2e pipeline, counted in enabled cycles.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid input NUM_REQ, req_data input NUM_REQ*DATA_WIDTH (requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]), and req_ready output NUM_REQ.
REQ-007 SHALL have ports rsp_valid output NUM_REQ, rsp_ready input NUM_REQ, and rsp_data output DATA_WIDTH, shared by all requesters.
REQ-008 SHALL have ports pipe_op output DATA_WIDTH, pipe_vld_in output 1, pipe_en output 1, pipe_result input DATA_WIDTH, and pipe_vld_out input 1, all connecting to the pipeline.
REQ-009 SHALL have ports drain_req input 1, drained output 1, busy output 1, and inflight output clog2(PIPE_LAT+1).

Function
REQ-010 SHALL grant round-robin: among asserted req_valid bits, pick the first index strictly after last-granted pointer lg (wrapping); lg updates to the issued index on issue only.
REQ-011 SHALL drive req_ready[i]=1 only for the granted index, only when state==RUN and pipe_en==1; other bits 0. req_ready may depend combinationally on req_valid.
REQ-012 SHALL issue on req_valid[g] & req_ready[g], same cycle: pipe_vld_in=1, pipe_op=req_data[g]. Otherwise pipe_vld_in=0 and pipe_op=0.
REQ-013 SHALL hold a PIPE_LAT-deep tag shift register (index + valid). When pipe_en==1: stage0<=issue tag, stage k<=stage k-1. When pipe_en==0: hold.
REQ-014 SHALL route pipe_result to rsp_data unchanged; rsp_valid[t]=pipe_vld_out & (tail tag == t) & tail valid; all other bits 0.
REQ-015 SHALL drive pipe_en = ~(pipe_vld_out & ~rsp_ready[t]), combinationally. A stall freezes the pipeline, tags and issue. Bubbles (pipe_vld_out==0) never stall.
REQ-016 SHALL count in-flight ops: +1 on issue, -1 on response handshake (rsp_valid[t]&rsp_ready[t]), no change when both occur in one cycle; max PIPE_LAT, never underflows. inflight shows the register; busy = (inflight!=0).
REQ-017 SHALL implement FSM RUN/DRAIN/DRAINED:
- RUN->DRAIN when drain_req=1.
- DRAIN->DRAINED when inflight==0, regardless of drain_req.
- DRAINED->RUN when drain_req=0.
- drained=1 only in DRAINED.
- No issue in DRAIN or DRAINED; responses still complete.
REQ-018 SHALL register drain_req=1 in RUN with inflight==0 as RUN->DRAIN, then DRAINED on the next cycle (2 cycles minimum).
REQ-019 SHALL ensure a requester whose req_valid drops before grant loses nothing; an issued op is never dropped or duplicated.
REQ-020 SHALL return responses to the same requester in issue order.

Reset
REQ-021 SHALL on rst_n=0, asynchronously: state=RUN, lg=NUM_REQ-1 (requester 0 first), tags invalid, inflight=0.
REQ-022 SHALL drive these outputs 0 in reset: req_ready, rsp_valid, pipe_vld_in, pipe_op, drained, busy.
REQ-023 SHALL drive pipe_en=1 in reset.
REQ-024 SHALL discard in-flight operations on reset mid-operation; the pipeline shares rst_n and clears too.

Verification
REQ-025 SHALL cover, with a PIPE_LAT=3 pipeline model, a single op: req_valid=0001, req_data[0]=0x3F800000 at cycle 0 -> req_ready[0]=1, pipe_vld_in=1 at cycle 0; rsp_valid=0001, rsp_data=model(0x3F800000) at cycle 3; inflight 1 over cycles 1-3, 0 after.
REQ-026 SHALL cover all four requesters valid continuously after reset -> grant order 0,1,2,3,0; responses on rsp_valid bits in the same order, one per cycle, 3 cycles behind.
REQ-027 SHALL cover a stall with requester 1 result at the output and rsp_ready[1]=0 for 4 cycles -> pipe_en=0, req_ready=0, rsp_data stable for those 4 cycles; resumes the cycle rsp_ready[1]=1.
REQ-028 SHALL cover drain_req=1 with 3 ops in flight -> no further req_ready; drained=1 the cycle after the third response handshake; drain_req=0 -> RUN next cycle, issue resumes.
REQ-029 SHALL cover rst_n=0 asserted mid-stream with inflight=2 -> all outputs at reset values immediately; after release, no stale rsp_valid.
